apb_master_sched9: RTL and testbench

Multi-requester APB master scheduler. It shares one APB master bus (the apb_master_if9 signal set) among NREQ internal requesters using round-robin arbitration. It sequences the SETUP and ACCESS phases, decodes the one-hot psel9 from the address, and waits on pready9. It returns read data and pslverr9 to the granted requester. It sits between the UVC-driven requesters and the APB slave fabric.

---
 rtl/apb_master_sched9.sv | 189 ++++++++++++++++++
 tb/tb_apb_master_sched9.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_sched9.sv
// Round-robin scheduler sharing one APB master bus among NREQ requesters.
// Optional wait-state timeout is built when APB_SCHED_TIMEOUT_EN is defined.
module apb_master_sched9 #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned PADDR_WIDTH9   = 32,
  parameter int unsigned PWDATA_WIDTH9  = 32,
  parameter int unsigned PRDATA_WIDTH9  = 32,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            pclock9,
  input  logic                            preset9,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*PADDR_WIDTH9-1:0]    req_addr,
  input  logic [NREQ-1:0]                 req_write,
  input  logic [NREQ*PWDATA_WIDTH9-1:0]   req_wdata,
  output logic [NREQ-1:0]                 rsp_valid,
  output logic [PRDATA_WIDTH9-1:0]        rsp_rdata,
  output logic                            rsp_err,
  output logic [PADDR_WIDTH9-1:0]         paddr9,
  output logic                            prwd9,
  output logic [PWDATA_WIDTH9-1:0]        pwdata9,
  output logic                            penable9,
  output logic [15:0]                     psel9,
  input  logic                            pready9,
  input  logic [PRDATA_WIDTH9-1:0]        prdata9,
  input  logic                            pslverr9
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("apb_master_sched9: NREQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_sched9: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e                     state_q, state_d;
  logic [GW-1:0]              last_gnt_q, last_gnt_d;
  logic [PADDR_WIDTH9-1:0]    paddr_q, paddr_d;
  logic                       prwd_q, prwd_d;
  logic [PWDATA_WIDTH9-1:0]   pwdata_q, pwdata_d;
  logic                       penable_q, penable_d;
  logic [15:0]                psel_q, psel_d;
  logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [PRDATA_WIDTH9-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_err_q, rsp_err_d;

  logic                       gnt_any;
  logic [GW-1:0]              gnt_idx;
  logic [GW-1:0]              cand;
  logic [PADDR_WIDTH9-1:0]    gnt_addr;
  logic [PWDATA_WIDTH9-1:0]   gnt_wdata;

`ifdef APB_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]              wait_cnt_q, wait_cnt_d;
`endif

  // Round-robin search; iterating downward lets the nearest index after last_gnt win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = GW'((32'(last_gnt_q) + 32'(i)) % NREQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_addr  = req_addr[32'(gnt_idx) * PADDR_WIDTH9 +: PADDR_WIDTH9];
  assign gnt_wdata = req_wdata[32'(gnt_idx) * PWDATA_WIDTH9 +: PWDATA_WIDTH9];

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && !preset9 && gnt_any) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    paddr_d     = paddr_q;
    prwd_d      = prwd_q;
    pwdata_d    = pwdata_q;
    penable_d   = penable_q;
    psel_d      = psel_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_SCHED_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d    = S_SETUP;
          last_gnt_d = gnt_idx;
          paddr_d    = gnt_addr;
          prwd_d     = req_write[gnt_idx];
          pwdata_d   = req_write[gnt_idx] ? gnt_wdata : '0;
          psel_d     = 16'(1) << gnt_addr[SEL_LSB +: 4];
          penable_d  = 1'b0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (pready9) begin
          state_d     = S_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << last_gnt_q;
          rsp_rdata_d = prwd_q ? '0 : prdata9;
          rsp_err_d   = pslverr9;
        end
`ifdef APB_SCHED_TIMEOUT_EN
        // Abort on the wait cycle that brings the counter to the limit.
        else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << last_gnt_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclock9) begin
    if (preset9) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= GW'(NREQ - 1);
      paddr_q     <= '0;
      prwd_q      <= 1'b0;
      pwdata_q    <= '0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      paddr_q     <= paddr_d;
      prwd_q      <= prwd_d;
      pwdata_q    <= pwdata_d;
      penable_q   <= penable_d;
      psel_q      <= psel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_SCHED_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign paddr9    = paddr_q;
  assign prwd9     = prwd_q;
  assign pwdata9   = pwdata_q;
  assign penable9  = penable_q;
  assign psel9     = psel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_sched9.sv
// Scoreboard bench for apb_master_sched9: directed requests, expected responses
// queued at grant time and checked by an independent response monitor.
module tb_apb_master_sched9;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] KEY  = 32'hC0DE_0000;

  logic                   pclock9 = 1'b0;
  logic                   preset9;
  logic [NREQ-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [31:0]            rsp_rdata, paddr9, pwdata9, prdata9;
  logic                   rsp_err, prwd9, penable9, pready9, pslverr9;
  logic [15:0]            psel9;

  int          slv_wait;
  logic        slv_err, use_fixed, force_ready;
  logic [31:0] slv_rdata;
  int          wcnt;
  int          cyc;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [31:0]     d;
    logic            e;
    int              c;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;

  int checks   = 0;
  int failures = 0;

  apb_master_sched9 #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .pclock9(pclock9), .preset9(preset9),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr9(paddr9), .prwd9(prwd9), .pwdata9(pwdata9), .penable9(penable9),
    .psel9(psel9), .pready9(pready9), .prdata9(prdata9), .pslverr9(pslverr9)
  );

  always #5 pclock9 = ~pclock9;
  always @(posedge pclock9) cyc <= cyc + 1;

  // Slave model: ready after slv_wait wait states, read data derived from address.
  always_comb begin
    pready9  = force_ready | ((psel9 != 16'h0) && penable9 && (wcnt == slv_wait));
    prdata9  = use_fixed ? slv_rdata : (paddr9 ^ KEY);
    pslverr9 = slv_err & pready9;
  end
  always @(posedge pclock9) begin
    if ((psel9 != 16'h0) && penable9 && !pready9) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge pclock9) begin
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        e_mon = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e_mon.v));
        chk("rsp_rdata", rsp_rdata, e_mon.d);
        chk("rsp_err", 32'(rsp_err), 32'(e_mon.e));
        chk("rsp_cycle", cyc, e_mon.c);
      end
    end
  end

  // Raise one request, wait for its grant, queue the expected response, return in SETUP.
  task automatic issue(input int idx, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input int lat, input logic [31:0] erd,
                       input logic ee, input bit push, output int acc);
    int n;
    @(negedge pclock9);
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    req_write[idx]          = wr;
    req_valid[idx]          = 1'b1;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge pclock9);
      #1;
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1) << idx);
    acc = cyc;
    if (push) q.push_back(exp_t'{v: NREQ'(1) << idx, d: erd, e: ee, c: cyc + 3 + lat});
    @(negedge pclock9);
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, n, prev, exp_i;
    logic [31:0] a;
    preset9 = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    slv_wait = 0; slv_err = 1'b0; use_fixed = 1'b0; slv_rdata = '0; force_ready = 1'b0;

    // Reset: no accept even with a pending request
    @(negedge pclock9);
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = 32'h0000_3004;
    #1 chk("ready_in_reset", 32'(req_ready), 32'h0);
    @(negedge pclock9);
    chk("rst_psel", 32'(psel9), 32'h0);
    chk("rst_penable", 32'(penable9), 32'h0);
    chk("rst_paddr", paddr9, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    req_valid[0] = 1'b0;
    preset9 = 1'b0;

    // Single zero-wait read
    use_fixed = 1'b1; slv_rdata = 32'hDEAD_BEEF;
    issue(0, 32'h0000_3004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
    chk("t1_setup_psel", 32'(psel9), 32'h0008);
    chk("t1_setup_penable", 32'(penable9), 32'h0);
    chk("t1_setup_paddr", paddr9, 32'h0000_3004);
    @(negedge pclock9);
    chk("t1_access_psel", 32'(psel9), 32'h0008);
    chk("t1_access_penable", 32'(penable9), 32'h1);
    @(negedge pclock9);
    chk("t1_done_psel", 32'(psel9), 32'h0);
    chk("t1_done_penable", 32'(penable9), 32'h0);
    use_fixed = 1'b0;

    // Write with two wait states
    slv_wait = 2;
    issue(2, 32'h0000_1000, 1'b1, 32'h55, 2, 32'h0, 1'b0, 1'b1, acc);
    chk("t2_setup_psel", 32'(psel9), 32'h0002);
    chk("t2_setup_prwd", 32'(prwd9), 32'h1);
    chk("t2_setup_pwdata", pwdata9, 32'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclock9);
      chk("t2_access_penable", 32'(penable9), 32'h1);
      chk("t2_access_pwdata", pwdata9, 32'h55);
    end
    @(negedge pclock9);
    chk("t2_done_penable", 32'(penable9), 32'h0);
    chk("t2_hold_paddr", paddr9, 32'h0000_1000);
    slv_wait = 0;

    // Slave error on req1, then a clean transfer
    slv_err = 1'b1;
    issue(1, 32'h0000_F010, 1'b0, 32'h77, 0, 32'h0000_F010 ^ KEY, 1'b1, 1'b1, acc);
    chk("t4_setup_psel", 32'(psel9), 32'h8000);
    chk("t4_read_pwdata", pwdata9, 32'h0);
    @(negedge pclock9);
    @(negedge pclock9);
    slv_err = 1'b0;
    issue(3, 32'h0000_0020, 1'b0, 32'h0, 0, 32'h0000_0020 ^ KEY, 1'b0, 1'b1, acc);
    chk("t4b_setup_psel", 32'(psel9), 32'h0001);
    @(negedge pclock9);
    @(negedge pclock9);

    // Reset while in ACCESS
    slv_wait = 1000;
    issue(3, 32'h0000_2000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, acc);
    chk("t5_setup_psel", 32'(psel9), 32'h0004);
    @(negedge pclock9);
    chk("t5_access_penable", 32'(penable9), 32'h1);
    @(negedge pclock9);
    preset9 = 1'b1;
    @(negedge pclock9);
    chk("t5_rst_psel", 32'(psel9), 32'h0);
    chk("t5_rst_penable", 32'(penable9), 32'h0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    preset9 = 1'b0;
    slv_wait = 0;

    // Round-robin with all requesters held high
    for (int i = 0; i < NREQ; i++) begin
      a = 32'h0000_0100 | (32'(i) << 12);
      req_addr[i*AW +: AW] = a;
      req_write[i] = 1'b0;
    end
    req_valid = '1;
    #1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      exp_i = g % NREQ;
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(negedge pclock9);
        #1;
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(1) << exp_i);
      if (g > 0) chk("rr_spacing", cyc - prev, 32'd3);
      prev = cyc;
      a = 32'h0000_0100 | (32'(exp_i) << 12);
      q.push_back(exp_t'{v: NREQ'(1) << exp_i, d: a ^ KEY, e: 1'b0, c: cyc + 3});
      @(negedge pclock9);
      if (g == 4) req_valid = '0;
      else #1;
    end
    @(negedge pclock9);
    @(negedge pclock9);

`ifdef APB_SCHED_TIMEOUT_EN
    // Wait-state timeout, then a late ready pulse that must be ignored
    slv_wait = 1000;
    issue(0, 32'h0000_3000, 1'b0, 32'h0, 15, 32'h0, 1'b1, 1'b1, acc);
    n = 0;
    @(negedge pclock9);
    while (penable9 && n < 40) begin
      n++;
      @(negedge pclock9);
    end
    chk("t6_access_cycles", n, 32'd16);
    force_ready = 1'b1;
    @(negedge pclock9);
    force_ready = 1'b0;
    chk("t6_late_ready_ignored", 32'(rsp_valid), 32'h0);
    slv_wait = 0;
`endif

    repeat (5) @(negedge pclock9);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
